// File: rtl/comp_scan_pkg.sv
// Shared types and widths for the minimum-cost scan block.
// Holds: scan FSM encoding, one-hot compare result, and default widths.
// No logic lives here; all timing/backpressure behaviour is in comp_scan.
package comp_scan_pkg;

  localparam int CMP_W = 16;
  localparam int ID_W  = 4;
  localparam int MAX_N = 16;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} scan_state_t;

  // Exactly one of lt/eq/gt is set for any pair of operands.
  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_res_t;

endpackage

// File: rtl/comp_scan_if.sv
// Candidate stream in, scan result out, both valid/ready.
// Pure wiring, no latency.
// master drives candidates and out_ready; slave drives in_ready and results.
interface comp_scan_if
  import comp_scan_pkg::*;
#(
  parameter int W    = CMP_W,
  parameter int IW   = ID_W,
  parameter int MAXN = MAX_N,
  parameter int CW   = $clog2(MAXN + 1)
);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_cost;
  logic [IW-1:0] in_id;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_cost;
  logic [IW-1:0] out_id;
  logic [CW-1:0] out_count;
  logic          out_tie;
  logic          out_ovf;

  modport master (
    output in_valid, in_cost, in_id, in_last, out_ready,
    input  in_ready, out_valid, out_cost, out_id, out_count, out_tie, out_ovf
  );

  modport slave (
    input  in_valid, in_cost, in_id, in_last, out_ready,
    output in_ready, out_valid, out_cost, out_id, out_count, out_tie, out_ovf
  );

endinterface

// File: rtl/comp_scan_cmp_mag.sv
// Unsigned magnitude compare of a against b, one-hot lt/eq/gt result.
// Purely combinational, zero latency.
// No handshake; result follows the operands.
module cmp_mag
  import comp_scan_pkg::*;
#(
  parameter int W = CMP_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output cmp_res_t     res
);

  // Full-width unsigned relations; exactly one holds.
  always_comb begin
    res.lt = (a < b);
    res.eq = (a == b);
    res.gt = (a > b);
  end

endmodule

// File: rtl/comp_scan.sv
// Sequential minimum-cost selector over a (cost, id) candidate stream.
// Result valid 1 clk after the last candidate is accepted.
// in_ready low only while a result is held; next scan starts the cycle after the result handshake.
module comp_scan
  import comp_scan_pkg::*;
#(
  parameter int W    = CMP_W,
  parameter int IW   = ID_W,
  parameter int MAXN = MAX_N
) (
  input logic        clk,
  input logic        rst,
  comp_scan_if.slave bus
);

  localparam int CW = $clog2(MAXN + 1);

  scan_state_t   state, state_n;
  logic [W-1:0]  best, best_n;
  logic [IW-1:0] bid, bid_n;
  logic [CW-1:0] count, count_n;
  logic          tie, tie_n;
  logic          ovf, ovf_n;
  logic          accept;
  cmp_res_t      cmp;

  cmp_mag #(.W(W)) u_cmp (
    .a   (bus.in_cost),
    .b   (best),
    .res (cmp)
  );

  // Next-state and handshake decode; ready depends on state only.
  always_comb begin
    state_n       = state;
    best_n        = best;
    bid_n         = bid;
    count_n       = count;
    tie_n         = tie;
    ovf_n         = ovf;
    bus.in_ready  = (state != HOLD);
    bus.out_valid = (state == HOLD);
    accept        = bus.in_valid & bus.in_ready;
    case (state)
      IDLE: begin
        if (accept) begin
          best_n  = bus.in_cost;
          bid_n   = bus.in_id;
          count_n = CW'(1);
          tie_n   = 1'b0;
          ovf_n   = 1'b0;
          state_n = bus.in_last ? HOLD : SCAN;
        end
      end
      SCAN: begin
        if (accept) begin
          // Strictly smaller replaces; equal keeps the earlier id but marks a tie.
          if (cmp.lt) begin
            best_n = bus.in_cost;
            bid_n  = bus.in_id;
          end
          if (cmp.eq) tie_n = 1'b1;
          // Count saturates; any beat beyond MAXN flags overflow.
          if (count == CW'(MAXN)) ovf_n = 1'b1;
          else                    count_n = count + CW'(1);
          if (bus.in_last) state_n = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and scan registers; reset discards any partial scan or pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      best  <= '0;
      bid   <= '0;
      count <= '0;
      tie   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      best  <= best_n;
      bid   <= bid_n;
      count <= count_n;
      tie   <= tie_n;
      ovf   <= ovf_n;
    end
  end

  assign bus.out_cost  = best;
  assign bus.out_id    = bid;
  assign bus.out_count = count;
  assign bus.out_tie   = tie;
  assign bus.out_ovf   = ovf;

endmodule

// File: tb/tb_comp_scan.sv
// Scoreboard bench for comp_scan: randomized and directed scans against a reference model.
// Expected results are queued at stimulus time and popped by a monitor on each result handshake.
// Also sweeps a 4-bit cmp_mag over every operand pair.
module tb_comp_scan;
  import comp_scan_pkg::*;

  localparam int W    = 16;
  localparam int IW   = 4;
  localparam int MAXN = 16;
  localparam int CW   = $clog2(MAXN + 1);

  typedef logic [W-1:0]  cost_q_t[$];
  typedef logic [IW-1:0] id_q_t[$];

  typedef struct {
    logic [W-1:0]  cost;
    logic [IW-1:0] id;
    logic [CW-1:0] count;
    logic          tie;
    logic          ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  comp_scan_if #(.W(W), .IW(IW), .MAXN(MAXN)) bus ();

  comp_scan #(.W(W), .IW(IW), .MAXN(MAXN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [3:0] ca, cb;
  cmp_res_t   cres;
  cmp_mag #(.W(4)) u_cmp4 (.a(ca), .b(cb), .res(cres));

  res_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   auto_rdy    = 1'b1;
  bit   man_rdy     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: minimum over the whole scan, earliest id among minima,
  // tie if any later cost equals the minimum of the costs before it.
  function automatic res_t model(input cost_q_t c, input id_q_t ids);
    res_t r;
    int n = c.size();
    logic [W-1:0] mn = c[0];
    for (int i = 1; i < n; i++) if (c[i] < mn) mn = c[i];
    r.cost = mn;
    r.id   = '0;
    for (int i = n - 1; i >= 0; i--) if (c[i] == mn) r.id = ids[i];
    r.tie = 1'b0;
    for (int i = 1; i < n; i++) begin
      logic [W-1:0] pm = c[0];
      for (int j = 1; j < i; j++) if (c[j] < pm) pm = c[j];
      if (c[i] == pm) r.tie = 1'b1;
    end
    r.count = (n > MAXN) ? CW'(MAXN) : CW'(n);
    r.ovf   = (n > MAXN);
    return r;
  endfunction

  // out_ready: random when auto_rdy, otherwise the value main sets in man_rdy.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = auto_rdy ? ($urandom_range(0, 2) != 0) : man_rdy;
    end
  end

  // Monitor: every held-result cycle is compared with the scoreboard head.
  res_t mexp;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result: got cost %0h with empty scoreboard", bus.out_cost);
        end else begin
          mexp = sbq[0];
          check("out_cost",  32'(bus.out_cost),  32'(mexp.cost));
          check("out_id",    32'(bus.out_id),    32'(mexp.id));
          check("out_count", 32'(bus.out_count), 32'(mexp.count));
          check("out_tie",   32'(bus.out_tie),   32'(mexp.tie));
          check("out_ovf",   32'(bus.out_ovf),   32'(mexp.ovf));
          check("in_ready_hold", 32'(bus.in_ready), 32'(0));
          if (bus.out_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one beat from posedge+1 phase; returns at posedge+1 after acceptance.
  task automatic drive_beat(input logic [W-1:0] c, input logic [IW-1:0] id, input logic last);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_cost  = c;
    bus.in_id    = id;
    bus.in_last  = last;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_scan(input cost_q_t c, input id_q_t ids);
    sbq.push_back(model(c, ids));
    for (int i = 0; i < c.size(); i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      drive_beat(c[i], ids[i], (i == c.size() - 1));
    end
    check("latency_out_valid", 32'(bus.out_valid), 32'(1));
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sbq.size() != 0 || bus.out_valid) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
    end
  endtask

  cost_q_t cq;
  id_q_t   iq;

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_cost  = '0;
    bus.in_id    = '0;
    bus.in_last  = 1'b0;
    ca = '0;
    cb = '0;

    // Exhaustive 4-bit comparator sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        ca = 4'(a);
        cb = 4'(b);
        #1;
        check("cmp4", 32'(cres), 32'({a < b, a == b, a > b}));
      end
    end

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_out_cost",  32'(bus.out_cost),  32'(0));
    check("rst_out_id",    32'(bus.out_id),    32'(0));
    check("rst_out_count", 32'(bus.out_count), 32'(0));
    check("rst_out_tie",   32'(bus.out_tie),   32'(0));
    check("rst_out_ovf",   32'(bus.out_ovf),   32'(0));
    check("rst_in_ready",  32'(bus.in_ready),  32'(1));
    @(posedge clk);
    #1;

    cq = {16'd5, 16'd3, 16'd9};     iq = {4'd0, 4'd1, 4'd2}; send_scan(cq, iq);
    cq = {16'd7, 16'd7};            iq = {4'd2, 4'd5};       send_scan(cq, iq);
    cq = {16'hFFFF};                iq = {4'd3};             send_scan(cq, iq);
    cq = {16'h0000, 16'hFFFF, 16'h0000}; iq = {4'd8, 4'd9, 4'd10}; send_scan(cq, iq);
    cq = {16'hFFFF, 16'hFFFF};      iq = {4'd1, 4'd4};       send_scan(cq, iq);
    wait_drain();

    // Stall the result for 3 clks, then check the one-cycle bubble.
    auto_rdy = 1'b0;
    man_rdy  = 1'b0;
    @(posedge clk);
    #1;
    cq = {16'd10, 16'd4}; iq = {4'd1, 4'd2}; send_scan(cq, iq);
    repeat (3) begin
      @(negedge clk);
      check("stall_out_valid", 32'(bus.out_valid), 32'(1));
      check("stall_in_ready",  32'(bus.in_ready),  32'(0));
    end
    @(posedge clk);
    #1;
    cq = {16'h0020}; iq = {4'd6};
    sbq.push_back(model(cq, iq));
    bus.in_valid = 1'b1;
    bus.in_cost  = 16'h0020;
    bus.in_id    = 4'd6;
    bus.in_last  = 1'b1;
    man_rdy      = 1'b1;
    @(negedge clk);
    check("handshake_cycle_in_ready", 32'(bus.in_ready), 32'(0));
    @(posedge clk);
    #1;
    man_rdy = 1'b0;
    @(negedge clk);
    check("bubble_in_ready",  32'(bus.in_ready),  32'(1));
    check("bubble_out_valid", 32'(bus.out_valid), 32'(0));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    check("after_bubble_out_valid", 32'(bus.out_valid), 32'(1));
    auto_rdy = 1'b1;
    @(posedge clk);
    #1;
    wait_drain();

    // Reset in the middle of a scan discards it.
    drive_beat(16'd100, 4'd1, 1'b0);
    drive_beat(16'd50,  4'd2, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'(0));
    check("midrst_in_ready",  32'(bus.in_ready),  32'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("postrst_out_valid", 32'(bus.out_valid), 32'(0));
    check("postrst_in_ready",  32'(bus.in_ready),  32'(1));
    check("postrst_out_count", 32'(bus.out_count), 32'(0));
    @(posedge clk);
    #1;
    cq = {16'h0000}; iq = {4'd7}; send_scan(cq, iq);
    wait_drain();

    // 17 beats: overflow, count saturation, minimum on the final beat.
    cq.delete();
    iq.delete();
    for (int i = 0; i < 16; i++) begin
      cq.push_back(16'($urandom_range(2, 65535)));
      iq.push_back(4'($urandom_range(0, 15)));
    end
    cq.push_back(16'd1);
    iq.push_back(4'd11);
    send_scan(cq, iq);
    wait_drain();

    // Random scans, narrow cost range for ties, wide range for extremes.
    for (int s = 0; s < 40; s++) begin
      int n = $urandom_range(1, 20);
      bit narrow = ($urandom_range(0, 1) == 1);
      cq.delete();
      iq.delete();
      for (int i = 0; i < n; i++) begin
        if (narrow) cq.push_back(16'($urandom_range(0, 7)));
        else        cq.push_back(16'($urandom_range(0, 65535)));
        iq.push_back(4'($urandom_range(0, 15)));
      end
      send_scan(cq, iq);
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
